// File: rtl/volatility_engine_if.sv
// Sample/result bus of the volatility engine: master drives samples and result back-pressure,
// slave (the engine) returns ready and per-stock variance results.
interface volatility_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STOCKS = 4
);
    localparam int ID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

    // A sample moves on i_valid && o_ready; a result moves on o_valid && i_out_ready.
    // Neither valid may depend on the other side's ready.
    logic                    i_valid;
    logic                    o_ready;
    logic [ID_W-1:0]         i_stock_id;
    logic [DATA_WIDTH-1:0]   i_best_bid;
    logic [DATA_WIDTH-1:0]   i_best_ask;
    logic                    i_clear;
    logic                    o_valid;
    logic                    i_out_ready;
    logic [ID_W-1:0]         o_stock_id;
    logic [DATA_WIDTH-1:0]   o_curr_price;
    logic [2*DATA_WIDTH-1:0] o_variance;
    logic                    o_buffer_full;

    modport master (
        output i_valid, i_stock_id, i_best_bid, i_best_ask, i_clear, i_out_ready,
        input  o_ready, o_valid, o_stock_id, o_curr_price, o_variance, o_buffer_full
    );

    modport slave (
        input  i_valid, i_stock_id, i_best_bid, i_best_ask, i_clear, i_out_ready,
        output o_ready, o_valid, o_stock_id, o_curr_price, o_variance, o_buffer_full
    );
endinterface

// File: rtl/volatility_engine.sv
// Rolling-window mid-price variance per stock: accept/read-old stage, running-sum stage,
// square/scale stage and subtract/clamp output stage; the whole pipe stalls on back-pressure.
module volatility_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 32,
    parameter int NUM_STOCKS  = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    volatility_engine_if.slave bus
);
    localparam int L    = $clog2(BUFFER_SIZE);
    localparam int ID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
    localparam int W1   = DATA_WIDTH + L;
    localparam int W2   = 2*DATA_WIDTH + L;
    localparam int WP   = 2*DATA_WIDTH + 2*L;
    localparam int VW   = 2*DATA_WIDTH;
    localparam logic [L:0] FULL_CNT = (L+1)'(BUFFER_SIZE);

    // Per-stock state
    logic [DATA_WIDTH-1:0] mem_q [NUM_STOCKS][BUFFER_SIZE];
    logic [L-1:0]          wp_q  [NUM_STOCKS];
    logic [L:0]            cnt_q [NUM_STOCKS];
    logic [W1-1:0]         s1_q  [NUM_STOCKS];
    logic [W2-1:0]         s2_q  [NUM_STOCKS];

    // Pipeline registers
    logic                  p1_valid_q, p2_valid_q, p3_valid_q, o_valid_q;
    logic [ID_W-1:0]       p1_id_q, p2_id_q, p3_id_q, o_stock_id_q;
    logic [DATA_WIDTH-1:0] p1_mid_q, p2_mid_q, p3_mid_q, o_curr_price_q;
    logic [DATA_WIDTH-1:0] p1_old_q;
    logic                  p1_full_q, p2_full_q, p3_full_q, o_buffer_full_q;
    logic [W1-1:0]         p2_s1_q;
    logic [W2-1:0]         p2_s2_q;
    logic [WP-1:0]         p3_a_q, p3_b_q;
    logic [VW-1:0]         o_variance_q;

    logic                  ready, accept, both_zero, sample_go, clear_go;
    logic [ID_W-1:0]       in_id;
    logic [DATA_WIDTH-1:0] mid_d, old_d;
    logic [L:0]            cnt_d;
    logic [W1-1:0]         s1_d;
    logic [W2-1:0]         s2_d;
    logic [VW-1:0]         v_d;

    always_comb begin
        ready     = !o_valid_q || bus.i_out_ready;
        accept    = bus.i_valid && ready;
        in_id     = bus.i_stock_id;
        both_zero = (bus.i_best_bid == '0) && (bus.i_best_ask == '0);
        clear_go  = accept && bus.i_clear;
        sample_go = accept && !bus.i_clear && !both_zero;

        if (bus.i_best_bid == '0)      mid_d = bus.i_best_ask;
        else if (bus.i_best_ask == '0) mid_d = bus.i_best_bid;
        else mid_d = DATA_WIDTH'(({1'b0, bus.i_best_bid} + {1'b0, bus.i_best_ask}) >> 1);

        // Until the window is full the overwritten slot holds nothing meaningful.
        old_d = (cnt_q[in_id] == FULL_CNT) ? mem_q[in_id][wp_q[in_id]] : '0;
        cnt_d = (cnt_q[in_id] == FULL_CNT) ? FULL_CNT : cnt_q[in_id] + (L+1)'(1);

        s1_d = s1_q[p1_id_q] + W1'(p1_mid_q) - W1'(p1_old_q);
        s2_d = s2_q[p1_id_q] + W2'(p1_mid_q) * W2'(p1_mid_q) - W2'(p1_old_q) * W2'(p1_old_q);

        v_d = (p3_a_q < p3_b_q) ? '0 : VW'((p3_a_q - p3_b_q) >> (2*L));
    end

    always_ff @(posedge i_clk) begin
        if (sample_go) mem_q[in_id][wp_q[in_id]] <= mid_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                wp_q[i]  <= '0;
                cnt_q[i] <= '0;
                s1_q[i]  <= '0;
                s2_q[i]  <= '0;
            end
            p1_valid_q <= 1'b0; p1_id_q <= '0; p1_mid_q <= '0; p1_old_q <= '0; p1_full_q <= 1'b0;
            p2_valid_q <= 1'b0; p2_id_q <= '0; p2_mid_q <= '0; p2_full_q <= 1'b0;
            p2_s1_q    <= '0;   p2_s2_q <= '0;
            p3_valid_q <= 1'b0; p3_id_q <= '0; p3_mid_q <= '0; p3_full_q <= 1'b0;
            p3_a_q     <= '0;   p3_b_q  <= '0;
            o_valid_q  <= 1'b0; o_stock_id_q <= '0; o_curr_price_q <= '0;
            o_variance_q <= '0; o_buffer_full_q <= 1'b0;
        end else if (ready) begin
            p1_valid_q <= sample_go;
            p1_id_q    <= in_id;
            p1_mid_q   <= mid_d;
            p1_old_q   <= old_d;
            p1_full_q  <= (cnt_d == FULL_CNT);
            if (sample_go) begin
                wp_q[in_id]  <= wp_q[in_id] + L'(1);
                cnt_q[in_id] <= cnt_d;
            end
            if (p1_valid_q) begin
                s1_q[p1_id_q] <= s1_d;
                s2_q[p1_id_q] <= s2_d;
            end
            // A clear is younger than the sample in stage 1, so it must win on the same stock.
            if (clear_go) begin
                wp_q[in_id]  <= '0;
                cnt_q[in_id] <= '0;
                s1_q[in_id]  <= '0;
                s2_q[in_id]  <= '0;
            end

            p2_valid_q <= p1_valid_q;
            p2_id_q    <= p1_id_q;
            p2_mid_q   <= p1_mid_q;
            p2_full_q  <= p1_full_q;
            p2_s1_q    <= s1_d;
            p2_s2_q    <= s2_d;

            p3_valid_q <= p2_valid_q;
            p3_id_q    <= p2_id_q;
            p3_mid_q   <= p2_mid_q;
            p3_full_q  <= p2_full_q;
            p3_a_q     <= WP'(p2_s2_q) << L;
            p3_b_q     <= WP'(p2_s1_q) * WP'(p2_s1_q);

            o_valid_q       <= p3_valid_q;
            o_stock_id_q    <= p3_id_q;
            o_curr_price_q  <= p3_mid_q;
            o_variance_q    <= p3_full_q ? v_d : '0;
            o_buffer_full_q <= p3_full_q;
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_valid       = o_valid_q;
    assign bus.o_stock_id    = o_stock_id_q;
    assign bus.o_curr_price  = o_curr_price_q;
    assign bus.o_variance    = o_variance_q;
    assign bus.o_buffer_full = o_buffer_full_q;
endmodule

// File: tb/tb_volatility_engine.sv
// Directed bench for volatility_engine (4-deep window, 4 stocks): hand-computed results are
// queued on acceptance and popped by an independent output monitor.
module tb_volatility_engine;
    localparam int DW = 32;
    localparam int EW = 2 + DW + 2*DW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [EW-1:0] exp_q[$];

    volatility_engine_if #(.DATA_WIDTH(DW), .NUM_STOCKS(4)) bus ();

    volatility_engine #(.DATA_WIDTH(DW), .BUFFER_SIZE(4), .NUM_STOCKS(4)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] pk(input logic [1:0] id, input logic [DW-1:0] price,
                                         input logic [2*DW-1:0] vr, input logic full);
        return {id, price, vr, full};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Output monitor: pops on every completed result transfer and checks hold-while-stalled.
    logic [EW-1:0] prev_out;
    logic          hold_pending = 1'b0;
    always @(negedge clk) begin
        logic [EW-1:0] got, exp;
        got = {bus.o_stock_id, bus.o_curr_price, bus.o_variance, bus.o_buffer_full};
        if (rst_n && hold_pending) begin
            checks++;
            if (got !== prev_out || bus.o_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable: got %0h expected %0h", got, prev_out);
            end
        end
        hold_pending = rst_n && bus.o_valid && !bus.i_out_ready;
        prev_out     = got;
        if (rst_n && bus.o_valid && bus.i_out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL result: got %0h expected %0h", got, exp);
                end
            end
        end
    end

    task automatic send(input logic [1:0] id, input logic [DW-1:0] bid, input logic [DW-1:0] ask,
                        input logic clr, input logic exp_out, input logic [DW-1:0] e_price,
                        input logic [2*DW-1:0] e_var, input logic e_full);
        int n;
        bit done;
        bus.i_valid    = 1'b1;
        bus.i_stock_id = id;
        bus.i_best_bid = bid;
        bus.i_best_ask = ask;
        bus.i_clear    = clr;
        done = 0;
        n    = 0;
        while (!done) begin
            @(negedge clk);
            if (bus.o_ready) begin
                done = 1;
                if (exp_out) exp_q.push_back(pk(id, e_price, e_var, e_full));
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
                done = 1;
            end
        end
        bus.i_valid = 1'b0;
        bus.i_clear = 1'b0;
    endtask

    task automatic smp(input logic [1:0] id, input logic [DW-1:0] bid, input logic [DW-1:0] ask,
                       input logic [DW-1:0] e_price, input logic [2*DW-1:0] e_var, input logic e_full);
        send(id, bid, ask, 1'b0, 1'b1, e_price, e_var, e_full);
    endtask

    task automatic quiet(input logic [1:0] id, input logic [DW-1:0] bid, input logic [DW-1:0] ask,
                         input logic clr);
        send(id, bid, ask, clr, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_stock_id = '0; bus.i_best_bid = '0; bus.i_best_ask = '0;
        bus.i_clear = 1'b0; bus.i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("reset_ready", bus.o_ready, 1'b1);
        chk("reset_valid", bus.o_valid, 1'b0);
        chk("reset_id", bus.o_stock_id, 0);
        chk("reset_price", bus.o_curr_price, 0);
        chk("reset_var", bus.o_variance, 0);
        chk("reset_full", bus.o_buffer_full, 1'b0);
        @(posedge clk);
        #1;

        // Latency on an idle pipe, then interleaved stocks 0 and 1.
        smp(0, 2, 2, 2, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("latency_early", bus.o_valid, 1'b0);
        end
        @(negedge clk);
        chk("latency_3", bus.o_valid, 1'b1);
        @(posedge clk);
        #1;
        smp(1, 10, 10, 10, 0, 0);
        smp(0, 4, 4, 4, 0, 0);
        smp(1, 10, 10, 10, 0, 0);
        smp(0, 6, 6, 6, 0, 0);
        smp(1, 10, 10, 10, 0, 0);
        smp(0, 8, 8, 8, 5, 1);
        smp(1, 10, 10, 10, 0, 1);
        smp(0, 10, 10, 10, 5, 1);

        // Mid-price selection and the ignored all-zero quote on stock 2.
        smp(2, 0, 7, 7, 0, 0);
        quiet(2, 0, 0, 1'b0);
        smp(2, 5, 8, 6, 0, 0);
        smp(2, 9, 9, 9, 0, 0);
        smp(2, 2, 2, 2, 6, 1);
        smp(2, 11, 0, 11, 11, 1);

        // Near-maximum prices on stock 3, including a bid+ask sum above DATA_WIDTH.
        smp(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        smp(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        smp(3, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 0, 0);
        smp(3, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 4, 1);

        // Output back-pressure with a continuous input stream on stock 1.
        fork
            begin
                bus.i_out_ready = 1'b0;
                repeat (5) @(negedge clk);
                chk("ready_low_in_stall", bus.o_ready, 1'b0);
                @(posedge clk);
                #1 bus.i_out_ready = 1'b1;
            end
            begin
                smp(1, 14, 14, 14, 3, 1);
                smp(1, 14, 14, 14, 4, 1);
                smp(1, 14, 14, 14, 3, 1);
                smp(1, 14, 14, 14, 0, 1);
                smp(1, 10, 10, 10, 3, 1);
                smp(1, 18, 18, 18, 8, 1);
            end
        join

        // Clear right behind a sample on the same stock; stock 1 keeps its window.
        smp(0, 20, 20, 20, 29, 1);
        quiet(0, 9, 9, 1'b1);
        smp(0, 3, 3, 3, 0, 0);
        smp(0, 5, 5, 5, 0, 0);
        smp(0, 7, 7, 7, 0, 0);
        smp(0, 9, 9, 9, 5, 1);
        smp(1, 18, 18, 18, 11, 1);
        drain();

        // Reset with three samples in flight.
        quiet(2, 11, 11, 1'b0);
        quiet(2, 12, 12, 1'b0);
        quiet(2, 13, 13, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus.o_ready, 1'b1);
        repeat (4) begin
            chk("no_valid_after_reset", bus.o_valid, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        smp(0, 2, 2, 2, 0, 0);
        smp(0, 4, 4, 4, 0, 0);
        smp(0, 6, 6, 6, 0, 0);
        smp(0, 8, 8, 8, 5, 1);
        smp(2, 7, 7, 7, 0, 0);
        drain();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/volatility_engine.md
VOLATILITY_ENGINE -- requirements
Module: volatility_engine

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the bid, ask and mid-price integers.
REQ-002 Parameter: BUFFER_SIZE, default 32, rolling window depth per stock; power of two, at least 2.
REQ-003 Parameter: NUM_STOCKS, default 4, number of independent channels; at least 1.
REQ-004 Port: i_clk, input, 1, clock.
REQ-005 Port: i_reset_n, input, 1, reset (synchronous, active-low).
REQ-006 Port: i_valid, input, 1, input sample present.
REQ-007 Port: o_ready, output, 1, engine can accept a sample.
REQ-008 Port: i_stock_id, input, $clog2(NUM_STOCKS) (min 1), channel select.
REQ-009 Port: i_best_bid, input, DATA_WIDTH, best bid.
REQ-010 Port: i_best_ask, input, DATA_WIDTH, best ask.
REQ-011 Port: i_clear, input, 1, clear the i_stock_id channel; qualified by i_valid && o_ready.
REQ-012 Port: o_valid, output, 1, result present.
REQ-013 Port: i_out_ready, input, 1, downstream accepts result.
REQ-014 Port: o_stock_id, output, $clog2(NUM_STOCKS), channel of the result.
REQ-015 Port: o_curr_price, output, DATA_WIDTH, mid-price of the sample.
REQ-016 Port: o_variance, output, 2*DATA_WIDTH, integer window variance.
REQ-017 Port: o_buffer_full, output, 1, window holds BUFFER_SIZE samples, so o_variance is meaningful.

Function
REQ-018 Handshake: a transfer occurs when i_valid && o_ready; output consumed when o_valid && i_out_ready.
REQ-019 o_ready = !o_valid || i_out_ready.
REQ-020 The whole pipeline stalls when o_ready is 0; all stage registers hold their values.
REQ-021 Mid-price selection:
- bid=0 and ask!=0: mid = ask.
- ask=0 and bid!=0: mid = bid.
- both zero: accepted, no state change, no output.
- otherwise: mid = (bid+ask)>>1, summed in DATA_WIDTH+1 bits.
REQ-022 Each stock owns:
- a write pointer, log2(BUFFER_SIZE) bits, wrapping modulo BUFFER_SIZE;
- a count, saturating at BUFFER_SIZE;
- S1, width DATA_WIDTH+log2(BUFFER_SIZE);
- S2, width 2*DATA_WIDTH+log2(BUFFER_SIZE);
- BUFFER_SIZE sample slots.
REQ-023 Stage 0 (accept cycle), slot at the write pointer:
- the old value is read and the new mid written in the same cycle (read-before-write);
- the old value is treated as 0 while count < BUFFER_SIZE;
- the write pointer increments and the count increments (saturating).
REQ-024 Stage 1: S1 += mid - old; S2 += mid^2 - old^2.
REQ-025 Stage 1 sum updates are exact; back-to-back samples on the same stock are supported without bubbles or forwarding errors.
REQ-026 Stage 2 registers:
- A = S2 << log2(BUFFER_SIZE);
- B = S1^2, full-width product.
REQ-027 Stage 3 forms V = (A - B) >> (2*log2(BUFFER_SIZE)), truncated.
REQ-028 If A < B, V is clamped to 0.
REQ-029 o_variance = V when o_buffer_full = 1, otherwise 0.
REQ-030 Latency: an accepted sample produces o_valid exactly 3 cycles after acceptance when unstalled.
REQ-031 Results emerge in acceptance order.
REQ-032 o_buffer_full = 1 when the stock's count equals BUFFER_SIZE after this sample, including the filling sample.
REQ-033 Clear transaction: S1, S2, count and write pointer of i_stock_id are zeroed; no output is produced.
REQ-034 Clear takes priority over the sample carried in the same transfer.
REQ-035 Other stocks are unaffected by a clear or by samples on another stock.
REQ-036 The pipeline is 3 stages; one sample per cycle throughput.

Reset
REQ-037 While i_reset_n = 0 at a clock edge, the following are zeroed:
- all S1, S2, counts and write pointers;
- all pipeline valids;
- o_valid, o_stock_id, o_curr_price, o_variance, o_buffer_full.
REQ-038 Sample slots need not be cleared; count gating per REQ-023 makes stale data invisible.
REQ-039 Reset mid-operation discards all in-flight results.
REQ-040 o_ready = 1 in the first cycle after reset release.

Verification (BUFFER_SIZE=4, NUM_STOCKS=4, DATA_WIDTH=32)
REQ-041 Stock 0: mids 2,4,6,8 (bid=ask) -> outputs 1-3 have full=0, var=0; output 4 has full=1, var=5.
REQ-042 Then mid 10 on stock 0 (wrap overwrites 2) -> full=1, var=5, price=10.
REQ-043 Interleave stock 1 mids 10,10,10,10 with the stock 0 sequence above -> stock 1 var=0 full=1; stock 0 results unchanged.
REQ-044 Stimulus variants:
- bid=0, ask=7 -> price 7;
- bid=ask=0 -> no o_valid, no state change;
- bid=5, ask=8 -> price 6.
REQ-045 Hold i_out_ready=0 for 5 cycles with a continuous input stream -> o_ready=0; output held stable; no sample lost or duplicated after release.
REQ-046 Clear on stock 0 after full, then 3 samples -> full=0, var=0; 4th sample -> full=1.
REQ-047 Assert reset with 3 samples in flight -> no o_valid after release; sums restart from 0.
